// File: rtl/lsu.sv
// lsu: load/store unit bridging one core request to a 64-bit, 8-byte-aligned valid/ready memory bus.
// Latency: 3 cycles accept-to-resp_valid with an immediate bus, +1 per bus stall cycle; 1 cycle for errors.
// Backpressure: req_ready only in IDLE (depth 1); bus request fields held stable until mem_req_ready.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [2:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;

    logic        req_err;
    logic [7:0]  size_mask;
    logic [63:0] rd_shifted;
    logic [63:0] rd_ext;

    // Request legality: natural alignment for the access size, plus width codes with no meaning
    always_comb begin
        req_err = 1'b0;
        case (req_func3[1:0])
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = |req_addr[2:0];
        endcase
        if (req_we && req_func3[2]) begin
            req_err = 1'b1;
        end
        if (!req_we && (req_func3 == 3'b111)) begin
            req_err = 1'b1;
        end
    end

    // Byte-lane mask for the store size before it is moved to its lane offset
    always_comb begin
        case (req_func3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Align the returned doubleword to the access offset and extend per width/sign code
    always_comb begin
        rd_shifted = mem_rdata >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  rd_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  rd_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  rd_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'b100:  rd_ext = {56'd0, rd_shifted[7:0]};
            3'b101:  rd_ext = {48'd0, rd_shifted[15:0]};
            3'b110:  rd_ext = {32'd0, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // Next-state and registered-output computation; resp_valid is a one-cycle pulse into RESP
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        func3_d         = func3_q;
        off_d           = off_q;
        resp_valid_d    = 1'b0;
        resp_err_d      = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    off_d   = req_addr[2:0];
                    if (req_err) begin
                        // Faulting requests never touch the bus
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = req_we;
                        mem_addr_d      = {req_addr[63:3], 3'b000};
                        mem_wdata_d     = req_wdata << {req_addr[2:0], 3'b000};
                        mem_wmask_d     = req_we ? (size_mask << req_addr[2:0]) : 8'h00;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                // The bus response is only meaningful here; elsewhere it is stale and ignored
                if (mem_rsp_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (!we_q) begin
                        resp_rdata_d = rd_ext;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            func3_q         <= 3'd0;
            off_q           <= 3'd0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= 64'd0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 64'd0;
            mem_wdata_q     <= 64'd0;
            mem_wmask_q     <= 8'd0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            func3_q         <= func3_d;
            off_q           <= off_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_rdata_q    <= resp_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a bus-slave memory and a byte-addressed reference model.
// Directed vector table, reset-in-WAIT sequence, then randomized loads/stores with bus stalls.
// Bus slave applies backpressure per transaction; every DUT wait is bounded.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bus-slave storage (doubleword indexed) and reference storage (byte indexed)
    logic [63:0] bus_mem [logic [60:0]];
    logic [7:0]  ref_mem [logic [63:0]];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        bus_mem[a[63:3]] = d;
        for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = d[8*i +: 8];
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] n;
        n = 64'(nbytes(f3));
        return ((a % n) != 64'd0) || (we && f3[2]) || (!we && (f3 == 3'b111));
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] v;
        logic [7:0]  b;
        int          n;
        v = 64'd0;
        n = nbytes(f3);
        for (int i = 0; i < n; i++) begin
            b = ref_mem.exists(a + 64'(i)) ? ref_mem[a + 64'(i)] : 8'h00;
            v = v | (64'(b) << (8*i));
        end
        if (!f3[2] && (n < 8) && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[a + 64'(i)] = wd[8*i +: 8];
    endtask

    // Issue one request from an IDLE cycle and act as the bus slave until resp_valid
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int stall, input int dly,
                           output int lat, output logic err, output logic [63:0] rdata,
                           output bit saw_bus, output logic [63:0] c_addr, output logic c_we,
                           output logic [63:0] c_wdata, output logic [7:0] c_wmask);
        int          cyc, scnt, dcnt, phase;
        bit          acc_now, done;
        logic [63:0] old, bm;
        lat = -1; err = 1'b0; rdata = 64'd0; saw_bus = 1'b0;
        c_addr = 64'd0; c_we = 1'b0; c_wdata = 64'd0; c_wmask = 8'd0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
        cyc = 1; scnt = 0; dcnt = 0; phase = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; acc_now = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (resp_valid) begin
                lat = cyc; err = resp_err; rdata = resp_rdata; done = 1'b1;
            end else begin
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                if (mem_req_valid) begin
                    if (!saw_bus) begin
                        saw_bus = 1'b1; c_addr = mem_addr; c_we = mem_we;
                        c_wdata = mem_wdata; c_wmask = mem_wmask;
                    end else begin
                        chk("hold_addr",  mem_addr,        c_addr);
                        chk("hold_we",    64'(mem_we),     64'(c_we));
                        chk("hold_wdata", mem_wdata,       c_wdata);
                        chk("hold_wmask", 64'(mem_wmask),  64'(c_wmask));
                    end
                    if (scnt < stall) scnt++;
                    else begin mem_req_ready = 1'b1; acc_now = 1'b1; end
                end else if (phase == 1) begin
                    if (dcnt < dly) dcnt++;
                    else begin
                        mem_rsp_valid = 1'b1;
                        old = bus_mem.exists(c_addr[63:3]) ? bus_mem[c_addr[63:3]] : 64'd0;
                        if (c_we) begin
                            for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{c_wmask[i]}};
                            bus_mem[c_addr[63:3]] = (old & ~bm) | (c_wdata & bm);
                        end else begin
                            mem_rdata = old;
                        end
                    end
                end
                @(posedge clk); #1;
                cyc++;
                if (acc_now) phase = 1;
            end
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: no resp_valid within %0d cycles, required one", cyc);
        end else begin
            @(posedge clk); #1;
            chk("resp_pulse_width",     64'(resp_valid), 64'd0);
            chk("req_ready_after_resp", 64'(req_ready),  64'd1);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          stall;
        int          dly;
        int          lat;
        logic        err;
        logic [63:0] rdata;
        logic [63:0] maddr;
        logic [7:0]  wmask;
        logic [63:0] mwdata;
    } vec_t;

    vec_t tv [14];

    initial begin
        int          lat;
        logic        err, c_we;
        logic [63:0] rdata, c_addr, c_wdata, last_rdata;
        logic [7:0]  c_wmask;
        bit          saw_bus;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = 64'd0;

        //       we    f3      addr      wdata                  st dl lat err  rdata                   maddr     wmask  mwdata
        tv[0]  = '{1'b0, 3'b000, 64'h1007, 64'h0,                 0, 0, 3, 1'b0, 64'hFFFFFFFFFFFFFF88, 64'h1000, 8'h00, 64'h0};
        tv[1]  = '{1'b0, 3'b100, 64'h1007, 64'h0,                 0, 0, 3, 1'b0, 64'h0000000000000088, 64'h1000, 8'h00, 64'h0};
        tv[2]  = '{1'b1, 3'b001, 64'h2002, 64'hABCD,              0, 0, 3, 1'b0, 64'h0000000000000088, 64'h2000, 8'h0C, 64'h00000000ABCD0000};
        tv[3]  = '{1'b0, 3'b010, 64'h3002, 64'h0,                 0, 0, 1, 1'b1, 64'h0000000000000088, 64'h0,    8'h00, 64'h0};
        tv[4]  = '{1'b0, 3'b010, 64'h1004, 64'h0,                 4, 2, 9, 1'b0, 64'hFFFFFFFF88776655, 64'h1000, 8'h00, 64'h0};
        tv[5]  = '{1'b1, 3'b100, 64'h1000, 64'hFF,                0, 0, 1, 1'b1, 64'hFFFFFFFF88776655, 64'h0,    8'h00, 64'h0};
        tv[6]  = '{1'b1, 3'b011, 64'h1008, 64'hDEADBEEFCAFEF00D,  0, 0, 3, 1'b0, 64'hFFFFFFFF88776655, 64'h1008, 8'hFF, 64'hDEADBEEFCAFEF00D};
        tv[7]  = '{1'b0, 3'b011, 64'h1008, 64'h0,                 0, 0, 3, 1'b0, 64'hDEADBEEFCAFEF00D, 64'h1008, 8'h00, 64'h0};
        tv[8]  = '{1'b0, 3'b110, 64'h1004, 64'h0,                 1, 0, 4, 1'b0, 64'h0000000088776655, 64'h1000, 8'h00, 64'h0};
        tv[9]  = '{1'b0, 3'b001, 64'h1006, 64'h0,                 0, 3, 6, 1'b0, 64'hFFFFFFFFFFFF8877, 64'h1000, 8'h00, 64'h0};
        tv[10] = '{1'b0, 3'b101, 64'h1001, 64'h0,                 0, 0, 1, 1'b1, 64'hFFFFFFFFFFFF8877, 64'h0,    8'h00, 64'h0};
        tv[11] = '{1'b0, 3'b111, 64'h1000, 64'h0,                 0, 0, 1, 1'b1, 64'hFFFFFFFFFFFF8877, 64'h0,    8'h00, 64'h0};
        tv[12] = '{1'b1, 3'b000, 64'h2005, 64'hA5,                0, 0, 3, 1'b0, 64'hFFFFFFFFFFFF8877, 64'h2000, 8'h20, 64'h0000A50000000000};
        tv[13] = '{1'b0, 3'b011, 64'h2000, 64'h0,                 0, 0, 3, 1'b0, 64'h0000A500ABCD0000, 64'h2000, 8'h00, 64'h0};

        preload(64'h1000, 64'h8877665544332211);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",     64'(req_ready),     64'd1);
        chk("rst_resp_valid",    64'(resp_valid),    64'd0);
        chk("rst_resp_err",      64'(resp_err),      64'd0);
        chk("rst_resp_rdata",    resp_rdata,         64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_wmask",     64'(mem_wmask),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int v = 0; v < 14; v++) begin
            run_txn(tv[v].we, tv[v].f3, tv[v].addr, tv[v].wdata, tv[v].stall, tv[v].dly,
                    lat, err, rdata, saw_bus, c_addr, c_we, c_wdata, c_wmask);
            if (tv[v].we && !tv[v].err) ref_store(tv[v].f3, tv[v].addr, tv[v].wdata);
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(tv[v].lat));
            chk($sformatf("vec%0d_err", v),     64'(err), 64'(tv[v].err));
            chk($sformatf("vec%0d_rdata", v),   rdata,    tv[v].rdata);
            chk($sformatf("vec%0d_bus_seen", v), 64'(saw_bus), 64'(!tv[v].err));
            if (!tv[v].err) begin
                chk($sformatf("vec%0d_mem_addr", v),  c_addr,        tv[v].maddr);
                chk($sformatf("vec%0d_mem_we", v),    64'(c_we),     64'(tv[v].we));
                chk($sformatf("vec%0d_mem_wmask", v), 64'(c_wmask),  64'(tv[v].wmask));
                if (tv[v].we) chk($sformatf("vec%0d_mem_wdata", v), c_wdata, tv[v].mwdata);
            end
        end

        // Reset while waiting for the bus response
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b011; req_addr = 64'h1008; req_wdata = 64'd0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 64'd0;
        chk("rstseq_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("rstseq_in_wait", 64'(mem_req_valid), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready",     64'(req_ready),     64'd1);
        chk("arst_resp_valid",    64'(resp_valid),    64'd0);
        chk("arst_resp_err",      64'(resp_err),      64'd0);
        chk("arst_resp_rdata",    resp_rdata,         64'd0);
        chk("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("arst_mem_we",        64'(mem_we),        64'd0);
        chk("arst_mem_addr",      mem_addr,           64'd0);
        chk("arst_mem_wdata",     mem_wdata,          64'd0);
        chk("arst_mem_wmask",     64'(mem_wmask),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("stale_rsp_no_resp",  64'(resp_valid), 64'd0);
            chk("stale_rsp_idle",     64'(req_ready),  64'd1);
        end
        mem_rsp_valid = 1'b0;
        run_txn(1'b0, 3'b011, 64'h1000, 64'd0, 0, 0, lat, err, rdata, saw_bus, c_addr, c_we, c_wdata, c_wmask);
        chk("post_rst_ld_latency", 64'(lat), 64'd3);
        chk("post_rst_ld_err",     64'(err), 64'd0);
        chk("post_rst_ld_rdata",   rdata,    64'h8877665544332211);
        last_rdata = 64'h8877665544332211;

        // Randomized traffic against the reference model
        for (int k = 0; k < 8; k++) preload(64'h4000 + 64'(8*k), {$urandom, $urandom});
        for (int t = 0; t < 80; t++) begin
            logic        we, e;
            logic [2:0]  f3;
            logic [63:0] a, wd, exp_rd;
            int          st, dl, off, m;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 64'h4000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a - (a % 64'(nbytes(f3)));
            wd = {$urandom, $urandom};
            st = $urandom_range(0, 2);
            dl = $urandom_range(0, 2);
            e  = ref_err(we, f3, a);
            off = int'(a % 64'd8);
            m   = ((1 << nbytes(f3)) - 1) << off;
            exp_rd = (!e && !we) ? ref_load(f3, a) : last_rdata;
            run_txn(we, f3, a, wd, st, dl, lat, err, rdata, saw_bus, c_addr, c_we, c_wdata, c_wmask);
            if (we && !e) ref_store(f3, a, wd);
            chk("rand_latency", 64'(lat), e ? 64'd1 : 64'(3 + st + dl));
            chk("rand_err",     64'(err), 64'(e));
            chk("rand_rdata",   rdata,    exp_rd);
            chk("rand_bus_seen", 64'(saw_bus), 64'(!e));
            if (!e) begin
                chk("rand_mem_addr",  c_addr,       a - (a % 64'd8));
                chk("rand_mem_we",    64'(c_we),    64'(we));
                chk("rand_mem_wmask", 64'(c_wmask), we ? 64'(m[7:0]) : 64'd0);
                if (we) chk("rand_mem_wdata", c_wdata, wd << (8*off));
            end
            last_rdata = exp_rd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
